spi_flash_read: RTL and testbench
=================================

// Module: spi_flash_read
// PURPOSE
//   SPI-flash read initiator: issues READ (0x03) + 24-bit address and captures N bytes from MISO.
//   It is the read-side counterpart of the flash write/erase initiators (WREN/SE).
//   It drives the same flash pins (cs_n/sck/MOSI, mode 3, sck = sys_clk/4) and presents bytes to fabric as rd_data/rd_valid.
// PARAMETERS
//   LEN_W        16  width of rd_len (max bytes per transaction = 2^LEN_W-1)
//   CS_SETUP_CYC  4  sys_clk cycles cs_n low before first sck fall (>=1)
//   CS_HOLD_CYC   4  sys_clk cycles after last sck rise before cs_n high (>=1)
//   CS_DESEL_CYC 16  minimum sys_clk cycles cs_n high before next transaction may start
// PORTS
//   sys_clk   in   1      system clock
//   rst_n     in   1      reset, asynchronous, active-low
//   start     in   1      1-cycle request; sampled only when busy==0
//   addr      in   24     flash byte address, latched on accepted start
//   rd_len    in   LEN_W  byte count, latched on accepted start
//   MISO      in   1      flash serial data out
//   busy      out  1      high from cycle after accepted start until done
//   done      out  1      1-cycle pulse at end of transaction (after deselect time)
//   rd_data   out  8      last received byte, MSB-first assembled; held until next byte
//   rd_valid  out  1      1-cycle pulse, rd_data new this cycle
//   cs_n      out  1      flash chip select, active low
//   sck       out  1      serial clock, idles high
//   MOSI      out  1      serial data to flash
// BEHAVIOUR
//   Reset (async): cs_n=1, sck=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, FSM=IDLE; mid-transaction reset aborts immediately.
//   FSM: IDLE -> SETUP -> CMD(8b) -> ADDR(24b) [-> DUMMY(8b)] -> DATA(8*rd_len b) -> HOLD -> DESEL -> IDLE.
//   IDLE: start=1 latches addr/rd_len; rd_len==0 -> no bus activity, done pulses next cycle, busy stays 0.
//   SETUP: cs_n=0 for CS_SETUP_CYC cycles, sck=1.
//   Bit timing: 2-bit clk_cnt runs 0..3 in CMD/ADDR/DUMMY/DATA; at clk_cnt==0 sck<=0 and MOSI<=next bit (MSB first);
//     at clk_cnt==2 sck<=1 and MISO sampled into shift reg; bit counter advances at clk_cnt==3.
//   DUMMY and DATA: MOSI driven 0.
//   DATA: after 8th sample of a byte, rd_data<=byte and rd_valid=1 the following cycle; byte counter decrements.
//   HOLD: sck=1, cs_n=0 for CS_HOLD_CYC cycles; then cs_n=1; DESEL holds CS_DESEL_CYC cycles, then done=1 for one cycle, busy=0.
//   start while busy is ignored (no queueing). Address wrap at 0xFFFFFF is the flash's concern; block never alters addr.
//   Latency (default params, READ): start sampled at cycle 0 -> cs_n low cycle 1; first rd_valid cycle 165;
//     each later rd_valid exactly 32 cycles after the previous one.
// CONFIGURATION
//   FLASH_FAST_READ_EN defined: opcode 0x0B, DUMMY state inserted (8 sck, MOSI=0); first rd_valid shifts +32 cycles (197).
//   Undefined: opcode 0x03, no DUMMY state; DUMMY logic not synthesised.
// STRUCTURE
//   Shared package/include spi_flash_defs: opcodes READ=0x03, FAST_READ=0x0B, WREN=0x06, SE=0xD8, PP=0x02; sck divide ratio (4); FSM state encodings.
//   Sub-module spi_bit_engine: clk_cnt, sck generation, MOSI shift-out, MISO shift-in, bit-done strobe.
//   Top handles FSM, byte/phase counters, cs_n timing.
// TESTING (bench includes mode-3 flash model returning byte = addr[7:0]+i)
//   addr=0x012345, rd_len=1 -> MOSI bits 0x03,0x01,0x23,0x45; rd_valid once at cycle 165 with rd_data=0x45; done after DESEL.
//   rd_len=4, addr=0x0000FE -> rd_data 0xFE,0xFF,0x00,0x01, rd_valid spaced 32 cycles; cs_n low continuously until HOLD.
//   rd_len=0 -> cs_n/sck never toggle; done 1 cycle after start; busy stays 0.
//   second start during busy -> ignored; exactly one transaction on bus; second start after done -> accepted.
//   rst_n low mid-ADDR -> cs_n=1, sck=1, busy=0 immediately; no rd_valid/done; next start runs a full clean transaction.
//   FLASH_FAST_READ_EN defined -> opcode 0x0B, 8 dummy sck with MOSI=0, first rd_valid at cycle 197.

Source files
------------

// File: rtl/spi_flash_read_pkg.sv
// Shared SPI-flash definitions: opcodes, sck divide ratio and read FSM state encoding.
// Build option: FLASH_FAST_READ_EN selects FAST_READ (0x0B) with 8 dummy clocks.
package spi_flash_read_pkg;

   localparam logic [7:0] OpRead     = 8'h03;
   localparam logic [7:0] OpFastRead = 8'h0B;
   localparam logic [7:0] OpWren     = 8'h06;
   localparam logic [7:0] OpSe       = 8'hD8;
   localparam logic [7:0] OpPp       = 8'h02;

   // sys_clk cycles per sck period
   localparam int unsigned SckDiv = 4;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StCmd,
      StAddr,
      StDummy,
      StData,
      StHold,
      StDesel
   } state_e;

   function automatic logic [7:0] read_opcode();
`ifdef FLASH_FAST_READ_EN
      return OpFastRead;
`else
      return OpRead;
`endif
   endfunction

endpackage

// File: rtl/spi_flash_read_bit_engine.sv
// Mode-3 bit engine: one bit per SckDiv sys_clk cycles. sck falls and MOSI updates on the
// first count, sck rises and MISO is sampled at mid-period, bit_done_o on the last count.
module spi_flash_read_bit_engine
   import spi_flash_read_pkg::*;
(
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic       tx_bit_i,
   input  logic       miso_i,
   output logic       sck_o,
   output logic       mosi_o,
   output logic [7:0] rx_byte_o,
   output logic       bit_done_o
);

   localparam logic [1:0] CntFall = 2'd0;
   localparam logic [1:0] CntRise = 2'(SckDiv / 2);
   localparam logic [1:0] CntLast = 2'(SckDiv - 1);

   logic [1:0] clk_cnt_q, clk_cnt_d;
   logic       sck_q, sck_d;
   logic       mosi_q, mosi_d;
   logic [7:0] rx_sr_q, rx_sr_d;

   // Next-state for the bit phase counter, sck, MOSI and the receive shifter.
   always_comb begin
      clk_cnt_d = clk_cnt_q;
      sck_d     = sck_q;
      mosi_d    = mosi_q;
      rx_sr_d   = rx_sr_q;
      if (!en_i) begin
         clk_cnt_d = '0;
         sck_d     = 1'b1;
         mosi_d    = 1'b0;
      end else begin
         clk_cnt_d = clk_cnt_q + 2'd1;
         if (clk_cnt_q == CntFall) begin
            sck_d  = 1'b0;
            mosi_d = tx_bit_i;
         end else if (clk_cnt_q == CntRise) begin
            sck_d   = 1'b1;
            rx_sr_d = {rx_sr_q[6:0], miso_i};
         end
      end
   end

   // Engine state registers; sck idles high out of reset.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_cnt_q <= '0;
         sck_q     <= 1'b1;
         mosi_q    <= 1'b0;
         rx_sr_q   <= '0;
      end else begin
         clk_cnt_q <= clk_cnt_d;
         sck_q     <= sck_d;
         mosi_q    <= mosi_d;
         rx_sr_q   <= rx_sr_d;
      end
   end

   assign sck_o      = sck_q;
   assign mosi_o     = mosi_q;
   assign rx_byte_o  = rx_sr_q;
   assign bit_done_o = en_i && (clk_cnt_q == CntLast);

endmodule

// File: rtl/spi_flash_read.sv
// SPI-flash read initiator: READ/FAST_READ + 24-bit address, then rd_len bytes from MISO.
// Build option: FLASH_FAST_READ_EN inserts 8 dummy clocks and uses opcode 0x0B.
module spi_flash_read
   import spi_flash_read_pkg::*;
#(
   parameter int unsigned LEN_W        = 16,
   parameter int unsigned CS_SETUP_CYC = 4,
   parameter int unsigned CS_HOLD_CYC  = 4,
   parameter int unsigned CS_DESEL_CYC = 16
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [23:0]      addr,
   input  logic [LEN_W-1:0] rd_len,
   input  logic             MISO,
   output logic             busy,
   output logic             done,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             cs_n,
   output logic             sck,
   output logic             MOSI
);

   localparam logic [15:0] SetupLast = 16'(CS_SETUP_CYC - 1);
   localparam logic [15:0] HoldLast  = 16'(CS_HOLD_CYC - 1);
   localparam logic [15:0] DeselLast = 16'(CS_DESEL_CYC - 1);

   state_e           state_q, state_d;
   logic [15:0]      cyc_cnt_q, cyc_cnt_d;
   logic [4:0]       bit_cnt_q, bit_cnt_d;
   logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [31:0]      tx_sr_q, tx_sr_d;
   logic             cs_n_q, cs_n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;

   logic             eng_en;
   logic             tx_bit;
   logic [7:0]       rx_byte;
   logic             bit_done;

   assign eng_en = (state_q == StCmd) || (state_q == StAddr) ||
                   (state_q == StDummy) || (state_q == StData);
   // Opcode and address are shifted out of one 32-bit register; dummy/data drive 0.
   assign tx_bit = ((state_q == StCmd) || (state_q == StAddr)) ? tx_sr_q[31] : 1'b0;

   spi_flash_read_bit_engine u_bit_engine (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .en_i       (eng_en),
      .tx_bit_i   (tx_bit),
      .miso_i     (MISO),
      .sck_o      (sck),
      .mosi_o     (MOSI),
      .rx_byte_o  (rx_byte),
      .bit_done_o (bit_done)
   );

   // Transaction FSM: phase sequencing, bit/byte counting and cs_n timing.
   always_comb begin
      state_d    = state_q;
      cyc_cnt_d  = cyc_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      tx_sr_d    = tx_sr_q;
      cs_n_d     = cs_n_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (rd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d    = StSetup;
                  tx_sr_d    = {read_opcode(), addr};
                  byte_cnt_d = rd_len;
                  busy_d     = 1'b1;
                  cs_n_d     = 1'b0;
                  cyc_cnt_d  = '0;
               end
            end
         end
         StSetup: begin
            if (cyc_cnt_q == SetupLast) begin
               state_d   = StCmd;
               cyc_cnt_d = '0;
               bit_cnt_d = '0;
            end else begin
               cyc_cnt_d = cyc_cnt_q + 16'd1;
            end
         end
         StCmd: begin
            if (bit_done) begin
               tx_sr_d = {tx_sr_q[30:0], 1'b0};
               if (bit_cnt_q == 5'd7) begin
                  state_d   = StAddr;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end
         StAddr: begin
            if (bit_done) begin
               tx_sr_d = {tx_sr_q[30:0], 1'b0};
               if (bit_cnt_q == 5'd23) begin
`ifdef FLASH_FAST_READ_EN
                  state_d = StDummy;
`else
                  state_d = StData;
`endif
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end
`ifdef FLASH_FAST_READ_EN
         StDummy: begin
            if (bit_done) begin
               if (bit_cnt_q == 5'd7) begin
                  state_d   = StData;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end
`endif
         StData: begin
            if (bit_done) begin
               if (bit_cnt_q == 5'd7) begin
                  // The 8th sample landed last cycle, so rx_byte is complete here.
                  rd_data_d  = rx_byte;
                  rd_valid_d = 1'b1;
                  bit_cnt_d  = '0;
                  byte_cnt_d = byte_cnt_q - LEN_W'(1);
                  if (byte_cnt_q == LEN_W'(1)) begin
                     state_d   = StHold;
                     cyc_cnt_d = '0;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end
         StHold: begin
            if (cyc_cnt_q == HoldLast) begin
               state_d   = StDesel;
               cs_n_d    = 1'b1;
               cyc_cnt_d = '0;
            end else begin
               cyc_cnt_d = cyc_cnt_q + 16'd1;
            end
         end
         StDesel: begin
            if (cyc_cnt_q == DeselLast) begin
               state_d = StIdle;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               cyc_cnt_d = cyc_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = StIdle;
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers; an asynchronous reset aborts any transaction on the spot.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cyc_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         tx_sr_q    <= '0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cyc_cnt_q  <= cyc_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         tx_sr_q    <= tx_sr_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_flash_read.sv
// Bench for spi_flash_read with a mode-3 flash model returning addr[7:0]+i per byte.
// Honours FLASH_FAST_READ_EN for opcode, dummy clocks and first-byte latency.
module tb_spi_flash_read;

`ifdef FLASH_FAST_READ_EN
   localparam int       Hdr   = 40;
   localparam bit [7:0] Opc   = 8'h0B;
   localparam int       First = 197;
`else
   localparam int       Hdr   = 32;
   localparam bit [7:0] Opc   = 8'h03;
   localparam int       First = 165;
`endif
   localparam int HoldDesel = 4 + 16;

   logic        sys_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic        start   = 1'b0;
   logic [23:0] addr    = '0;
   logic [15:0] rd_len  = '0;
   logic        MISO    = 1'b0;
   logic        busy, done, rd_valid, cs_n, sck, MOSI;
   logic [7:0]  rd_data;

   spi_flash_read dut (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .start    (start),
      .addr     (addr),
      .rd_len   (rd_len),
      .MISO     (MISO),
      .busy     (busy),
      .done     (done),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .cs_n     (cs_n),
      .sck      (sck),
      .MOSI     (MOSI)
   );

   always #5 sys_clk = ~sys_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int t0      = 0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // ---------------- flash model ----------------
   int        sck_rises = 0;
   int        rise_base = 0;
   logic [7:0]  m_cmd  = '0;
   logic [23:0] m_addr = '0;
   int        n_mosi_bad = 0;

   always @(negedge cs_n) rise_base <= sck_rises;

   always @(posedge sck) begin
      sck_rises <= sck_rises + 1;
      if (!cs_n) begin
         if (sck_rises - rise_base < 8) m_cmd <= {m_cmd[6:0], MOSI};
         else if (sck_rises - rise_base < 32) m_addr <= {m_addr[22:0], MOSI};
         else if (MOSI !== 1'b0) n_mosi_bad <= n_mosi_bad + 1;
      end
   end

   function automatic logic data_bit(input int idx);
      logic [7:0] b;
      b = m_addr[7:0] + 8'(idx / 8);
      return b[3'(7 - idx % 8)];
   endfunction

   always @(negedge sck) begin
      if (!cs_n && (sck_rises - rise_base >= Hdr)) MISO <= data_bit(sck_rises - rise_base - Hdr);
   end

   // ---------------- output monitor ----------------
   logic [7:0] got_data [256];
   int         got_at   [256];
   int         n_valid = 0, n_done = 0, done_at = 0, n_busy = 0;
   int         n_cs_fall = 0, n_cs_rise = 0, n_sck_fall = 0;
   logic       busy_at_done = 1'b0;
   logic       cs_prev = 1'b1, sck_prev = 1'b1;

   always @(negedge sys_clk) begin
      cs_prev  <= cs_n;
      sck_prev <= sck;
      if (rst_n) begin
         if (cs_prev && !cs_n) n_cs_fall <= n_cs_fall + 1;
         if (!cs_prev && cs_n) n_cs_rise <= n_cs_rise + 1;
         if (sck_prev && !sck) n_sck_fall <= n_sck_fall + 1;
      end
      if (busy) n_busy <= n_busy + 1;
      if (rd_valid && n_valid < 256) begin
         got_data[n_valid] <= rd_data;
         got_at[n_valid]   <= cyc - t0 + 1;
         n_valid           <= n_valid + 1;
      end
      if (done) begin
         n_done       <= n_done + 1;
         done_at      <= cyc - t0 + 1;
         busy_at_done <= busy;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [7:0] exp_q[$];
   int rd_ptr = 0;

   // Drive one accepted start and push the bytes the flash model will return.
   task automatic issue(input logic [23:0] a, input int len);
      for (int i = 0; i < len; i++) exp_q.push_back(a[7:0] + 8'(i));
      @(negedge sys_clk);
      addr   = a;
      rd_len = 16'(len);
      start  = 1'b1;
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      t0    = cyc;
   endtask

   task automatic wait_done(input string tag, input int d0, input int bound);
      for (int i = 0; i < bound && n_done == d0; i++) @(posedge sys_clk);
      @(posedge sys_clk);
      #1;
      chk({tag, ".done_cnt"}, 32'(n_done - d0), 32'd1);
   endtask

   // Pop expected bytes against whatever the DUT produced since v0.
   task automatic check_bytes(input string tag, input int v0, input int len);
      logic [7:0] e;
      chk({tag, ".n_valid"}, 32'(n_valid - v0), 32'(len));
      for (int i = 0; i < len; i++) begin
         e = exp_q.pop_front();
         if (rd_ptr < n_valid) begin
            chk($sformatf("%s.byte%0d", tag, i), 32'(got_data[rd_ptr]), 32'(e));
            chk($sformatf("%s.at%0d", tag, i), 32'(got_at[rd_ptr]), 32'(First + 32 * i));
            rd_ptr++;
         end
      end
      rd_ptr = n_valid;
   endtask

   task automatic run_txn(input string tag, input logic [23:0] a, input int len);
      int v0, d0, cf0, cr0, sf0, mb0;
      v0 = n_valid; d0 = n_done; cf0 = n_cs_fall; cr0 = n_cs_rise;
      sf0 = n_sck_fall; mb0 = n_mosi_bad;
      issue(a, len);
      chk({tag, ".busy1"}, 32'(busy), 32'd1);
      wait_done(tag, d0, First + 32 * len + 100);
      check_bytes(tag, v0, len);
      chk({tag, ".done_at"}, 32'(done_at), 32'(First + 32 * (len - 1) + HoldDesel));
      chk({tag, ".busy_at_done"}, 32'(busy_at_done), 32'd0);
      chk({tag, ".cmd"}, 32'(m_cmd), 32'(Opc));
      chk({tag, ".addr"}, 32'(m_addr), 32'(a));
      chk({tag, ".cs_fall"}, 32'(n_cs_fall - cf0), 32'd1);
      chk({tag, ".cs_rise"}, 32'(n_cs_rise - cr0), 32'd1);
      chk({tag, ".sck_falls"}, 32'(n_sck_fall - sf0), 32'(Hdr + 8 * len));
      chk({tag, ".mosi_zero"}, 32'(n_mosi_bad - mb0), 32'd0);
   endtask

   initial begin : wdog
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int v0, d0, cf0, sf0, b0;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst.cs_n", 32'(cs_n), 32'd1);
      chk("rst.sck", 32'(sck), 32'd1);
      @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;
      chk("rst.cs_n_rel", 32'(cs_n), 32'd1);
      chk("rst.sck_rel", 32'(sck), 32'd1);
      chk("rst.mosi", 32'(MOSI), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.rd_valid", 32'(rd_valid), 32'd0);
      chk("rst.rd_data", 32'(rd_data), 32'd0);

      run_txn("one", 24'h012345, 1);
      run_txn("four", 24'h0000FE, 4);

      // Zero-length request: no bus activity, done next cycle, never busy.
      d0 = n_done; cf0 = n_cs_fall; sf0 = n_sck_fall; b0 = n_busy;
      issue(24'h001000, 0);
      chk("zero.busy", 32'(busy), 32'd0);
      repeat (40) @(posedge sys_clk);
      #1;
      chk("zero.done_cnt", 32'(n_done - d0), 32'd1);
      chk("zero.done_at", 32'(done_at), 32'd1);
      chk("zero.cs_fall", 32'(n_cs_fall - cf0), 32'd0);
      chk("zero.sck_falls", 32'(n_sck_fall - sf0), 32'd0);
      chk("zero.busy_cnt", 32'(n_busy - b0), 32'd0);

      // Start while busy is dropped.
      v0 = n_valid; d0 = n_done; cf0 = n_cs_fall;
      issue(24'h000010, 2);
      repeat (20) @(posedge sys_clk);
      @(negedge sys_clk);
      addr = 24'h0000A0; rd_len = 16'd3; start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      wait_done("busy2", d0, First + 200);
      check_bytes("busy2", v0, 2);
      chk("busy2.addr", 32'(m_addr), 32'h10);
      chk("busy2.cs_fall", 32'(n_cs_fall - cf0), 32'd1);
      run_txn("after", 24'h0000A0, 1);

      // Reset in the address phase aborts at once and leaves no residue.
      v0 = n_valid; d0 = n_done;
      issue(24'h0ABCDE, 2);
      repeat (40) @(posedge sys_clk);
      @(negedge sys_clk);
      rst_n = 1'b0;
      #1;
      chk("abort.cs_n", 32'(cs_n), 32'd1);
      chk("abort.sck", 32'(sck), 32'd1);
      chk("abort.busy", 32'(busy), 32'd0);
      repeat (5) @(posedge sys_clk);
      @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (300) @(posedge sys_clk);
      #1;
      chk("abort.no_valid", 32'(n_valid - v0), 32'd0);
      chk("abort.no_done", 32'(n_done - d0), 32'd0);
      exp_q.delete();
      rd_ptr = n_valid;
      run_txn("clean", 24'h0000F0, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
